// File: rtl/sram_bus_adapter.sv
// Valid/ready word bus front end for the sram macro: active-low controls and a 2-entry response FIFO.
// Byte-strobe read-modify-write exists only when SRAM_ADAPTER_WSTRB_EN is defined.
module sram_bus_adapter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_W-1:0]     sram_wen,
    output logic [ADDR_W-1:0]     sram_a,
    output logic [DATA_W-1:0]     sram_d,
    input  logic [DATA_W-1:0]     sram_q
);
    localparam int NB = DATA_W / 8;

    logic              pend;
    logic              pend_wr;
    logic [1:0]        cnt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_wr;
    logic [1:0]        occ;
    logic              accept;
    logic              pop;
    logic              merging;
    logic              partial;
    logic              skip;
    logic [DATA_W-1:0] push_data;

`ifdef SRAM_ADAPTER_WSTRB_EN
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [NB-1:0]     m_wstrb;
    logic              full_strb;

    assign merging   = (state == MERGE);
    assign full_strb = &req_wstrb;
    assign skip      = req_write && ~|req_wstrb;
    assign partial   = accept && req_write && !full_strb && !skip;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else begin
            state <= partial ? MERGE : IDLE;
            if (partial) begin
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                m_wstrb <= req_wstrb;
            end
        end
    end
`else
    logic unused_wstrb;

    assign unused_wstrb = ^req_wstrb;
    assign merging      = 1'b0;
    assign skip         = 1'b0;
    assign partial      = 1'b0;
`endif

    // Pending capture counts as an occupied slot so a FIFO push never overflows.
    assign occ       = cnt + {1'b0, pend};
    assign rsp_valid = (cnt != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = RST_N && !merging && ((occ < 2'd2) || pop);
    assign accept    = req_valid && req_ready;
    assign rsp_write = rsp_valid && fifo_wr[rd_ptr];
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign push_data = pend_wr ? '0 : sram_q;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
`ifdef SRAM_ADAPTER_WSTRB_EN
        if (merging) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = m_addr;
            for (int i = 0; i < NB; i++) begin
                sram_d[8*i +: 8] = m_wstrb[i] ? m_wdata[8*i +: 8]
                                              : sram_q[8*i +: 8];
            end
        end else
`endif
        if (accept && !skip) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_write && !partial) begin
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_d    = req_wdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend         <= 1'b0;
            pend_wr      <= 1'b0;
            cnt          <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_wr      <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            // A merge cycle hands its write response to the capture stage.
            pend    <= (accept && !partial) || merging;
            pend_wr <= merging || req_write;
            if (pend) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_wr[wr_ptr]   <= pend_wr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Randomized bench for sram_bus_adapter with an in-bench macro model and
// a transaction-level reference of memory contents, response order and latency.
module tb_sram_bus_adapter;
    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int NB    = 4;
    localparam int DEPTH = 512;
`ifdef SRAM_ADAPTER_WSTRB_EN
    localparam bit STRB = 1'b1;
`else
    localparam bit STRB = 1'b0;
`endif
    localparam logic [DW-1:0] E_T2   = STRB ? 32'hDEADAAEF : 32'h0000AA00;
    localparam int            L_T2   = STRB ? 3 : 2;
    localparam logic [DW-1:0] E_ZERO = STRB ? 32'h77777777 : 32'hFFFFFFFF;
    localparam logic [DW-1:0] E_RST  = STRB ? 32'h11223344 : 32'hAABBCCDD;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NB-1:0] req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    always #5 CLK = ~CLK;

    sram_bus_adapter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    function automatic logic [DW-1:0] init_val(int i);
        return 32'hC0DE0000 ^ (i * 32'h9E3779B1);
    endfunction

    // Macro: one-cycle read latency, writes store ~WEN & D.
    logic [DW-1:0] mem [DEPTH];
    bit            mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= ~sram_wen & sram_d;
            else            sram_q      <= mem[sram_a];
        end
    end

    typedef struct {bit wr; logic [DW-1:0] data; int avail;} rsp_t;
    typedef struct {int cyc; logic [DW-1:0] data; bit wr;} pop_t;

    rsp_t          q[$];
    pop_t          pop_log[$];
    int            acc_log[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            cyc = 0;
    int            nchk = 0;
    int            nfail = 0;
    bit            rand_mode = 1'b0;
    bit            merge_flag = 1'b0;
    logic [AW-1:0] mpend_addr;
    logic [DW-1:0] mpend_data;
    logic [DW-1:0] last_merge_d;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    bit m_now, m_ev, m_ep, m_er, m_acc, m_part, m_zero;

    always @(negedge CLK) begin
        cyc++;
        m_now = merge_flag;
        if (!RST_N) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_write", rsp_write, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_cen", sram_cen, 1);
            chk("rst_gwen", sram_gwen, 1);
            chk("rst_wen", sram_wen, '1);
            q.delete();
            merge_flag = 1'b0;
        end else begin
            m_ev = (q.size() > 0) && (q[0].avail <= cyc);
            m_ep = m_ev && rsp_ready;
            m_er = !m_now && ((q.size() < 2) || m_ep);
            chk("rsp_valid", rsp_valid, m_ev);
            chk("req_ready", req_ready, m_er);
            if (m_ev) begin
                chk("rsp_write", rsp_write, q[0].wr);
                chk("rsp_rdata", rsp_rdata, q[0].data);
            end
            m_acc  = req_valid && m_er;
            m_zero = STRB && m_acc && req_write && (req_wstrb == 4'h0);
            m_part = STRB && m_acc && req_write && (req_wstrb != 4'h0) && (req_wstrb != 4'hF);
            if (m_now) begin
                chk("merge_cen", sram_cen, 0);
                chk("merge_gwen", sram_gwen, 0);
                chk("merge_wen", sram_wen, 0);
                chk("merge_a", sram_a, mpend_addr);
                chk("merge_d", sram_d, mpend_data);
                last_merge_d = sram_d;
                ref_mem[mpend_addr] = mpend_data;
            end else if (m_acc && !m_zero) begin
                chk("acc_cen", sram_cen, 0);
                chk("acc_a", sram_a, req_addr);
                chk("acc_gwen", sram_gwen, (req_write && !m_part) ? 0 : 1);
                if (req_write && !m_part) begin
                    chk("acc_wen", sram_wen, 0);
                    chk("acc_d", sram_d, req_wdata);
                end
            end else begin
                chk("idle_cen", sram_cen, 1);
                chk("idle_gwen", sram_gwen, 1);
                chk("idle_wen", sram_wen, '1);
                chk("idle_a", sram_a, 0);
                chk("idle_d", sram_d, 0);
            end
            if (m_ep) begin
                pop_log.push_back('{cyc, q[0].data, q[0].wr});
                void'(q.pop_front());
            end
            if (m_acc) begin
                acc_log.push_back(cyc);
                if (!req_write) begin
                    q.push_back('{1'b0, ref_mem[req_addr], cyc + 2});
                end else if (m_part) begin
                    mpend_addr = req_addr;
                    for (int b = 0; b < NB; b++)
                        mpend_data[8*b +: 8] = req_wstrb[b] ? req_wdata[8*b +: 8]
                                                            : ref_mem[req_addr][8*b +: 8];
                    q.push_back('{1'b1, 32'h0, cyc + 3});
                end else begin
                    if (!m_zero) ref_mem[req_addr] = req_wdata;
                    q.push_back('{1'b1, 32'h0, cyc + 2});
                end
            end
            merge_flag = m_part;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] s);
        bit acc = 1'b0;
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        while (!acc && n < 200) begin
            @(negedge CLK);
            acc = req_ready;
            tick();
            if (rand_mode) rsp_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        req_valid = 1'b0;
        if (rand_mode) begin
            req_write = $urandom_range(0, 1);
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            req_wstrb = NB'($urandom);
        end
    endtask

    task automatic wait_pops(int n);
        int k = 0;
        while (pop_log.size() < n && k < 200) begin
            tick();
            k++;
        end
        if (pop_log.size() < n) chk("pop_timeout", pop_log.size(), n);
    endtask

    task automatic single(bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] s,
                          output logic [DW-1:0] rd, output bit rw, output int lat);
        acc_log.delete();
        pop_log.delete();
        send(w, a, d, s);
        wait_pops(1);
        if (pop_log.size() > 0 && acc_log.size() > 0) begin
            rd  = pop_log[0].data;
            rw  = pop_log[0].wr;
            lat = pop_log[0].cyc - acc_log[0];
        end else begin
            rd  = 'x;
            rw  = 1'b0;
            lat = -1;
        end
    endtask

    logic [DW-1:0] rd;
    bit            rw;
    int            lat;
    int            mism;
    int            n;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_cen", sram_cen, 1);
        RST_N = 1'b1;
        tick();

        single(1'b1, 9'd5, 32'hDEADBEEF, 4'hF, rd, rw, lat);
        chk("t1_wr_lat", lat, 2);
        chk("t1_wr_rsp_write", rw, 1);
        chk("t1_wr_rdata", rd, 0);
        single(1'b0, 9'd5, 32'h0, 4'h0, rd, rw, lat);
        chk("t1_rd_lat", lat, 2);
        chk("t1_rd_rsp_write", rw, 0);
        chk("t1_rd_rdata", rd, 32'hDEADBEEF);

        single(1'b1, 9'd5, 32'h0000AA00, 4'b0010, rd, rw, lat);
        chk("t2_lat", lat, L_T2);
`ifdef SRAM_ADAPTER_WSTRB_EN
        chk("t2_merge_d", last_merge_d, 32'hDEADAAEF);
`endif
        single(1'b0, 9'd5, 32'h0, 4'h0, rd, rw, lat);
        chk("t2_read", rd, E_T2);

        for (int i = 0; i < 4; i++) single(1'b1, AW'(i), 32'h1000 + i, 4'hF, rd, rw, lat);
        acc_log.delete();
        pop_log.delete();
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 32'h0, 4'h0);
        wait_pops(4);
        if (acc_log.size() == 4 && pop_log.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t3_acc_cycle", acc_log[i] - acc_log[0], i);
            for (int i = 0; i < 4; i++) begin
                chk("t3_rsp_cycle", pop_log[i].cyc - acc_log[0], 2 + i);
                chk("t3_rsp_data", pop_log[i].data, 32'h1000 + i);
            end
        end else chk("t3_counts", acc_log.size() * 16 + pop_log.size(), 4 * 16 + 4);

        rsp_ready = 1'b0;
        acc_log.delete();
        pop_log.delete();
        send(1'b0, 9'd0, 32'h0, 4'h0);
        send(1'b0, 9'd1, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'd2;
        repeat (4) tick();
        chk("t4_accepts", acc_log.size(), 2);
        chk("t4_ready_low", req_ready, 0);
        chk("t4_head_held", rsp_rdata, 32'h1000);
        rsp_ready = 1'b1;
        send(1'b0, 9'd2, 32'h0, 4'h0);
        wait_pops(3);
        for (int i = 0; i < 3; i++)
            if (i < pop_log.size()) chk("t4_order", pop_log[i].data, 32'h1000 + i);

        single(1'b1, 9'd7, 32'h77777777, 4'hF, rd, rw, lat);
        single(1'b1, 9'd7, 32'hFFFFFFFF, 4'h0, rd, rw, lat);
        chk("t5_lat", lat, 2);
        chk("t5_rsp_write", rw, 1);
        single(1'b0, 9'd7, 32'h0, 4'h0, rd, rw, lat);
        chk("t5_read", rd, E_ZERO);

        single(1'b1, 9'd9, 32'h11223344, 4'hF, rd, rw, lat);
        send(1'b1, 9'd9, 32'hAABBCCDD, 4'b0101);
        RST_N = 1'b0;
        tick();
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_cen", sram_cen, 1);
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        chk("t6_no_rsp", rsp_valid, 0);
        single(1'b0, 9'd9, 32'h0, 4'h0, rd, rw, lat);
        chk("t6_read", rd, E_RST);

        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [NB-1:0] s;
            repeat ($urandom_range(0, 2)) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            case ($urandom_range(0, 3))
                0:       s = 4'hF;
                1:       s = 4'h0;
                default: s = NB'($urandom);
            endcase
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, s);
        end
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", q.size(), 0);
        repeat (2) tick();
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_final_mismatches", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
